// File: rtl/tetris_input_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tetris_input_pkg
// Shared definitions for the Tetris input path:
//   - button bit positions used on the press/release vectors
//   - command encoding seen by the game logic
//   - state encoding of the per-button auto-repeat FSM
// No ports; imported by key_repeat and input_scheduler.
// ---------------------------------------------------------------------------
package tetris_input_pkg;

  localparam int NUM_BTNS = 5;

  // Bit positions inside the press/release vectors
  localparam int BTN_LEFT      = 0;
  localparam int BTN_RIGHT     = 1;
  localparam int BTN_ROTATE    = 2;
  localparam int BTN_SOFT_DROP = 3;
  localparam int BTN_HARD_DROP = 4;

  localparam int CMD_W = 3;

  // Command codes presented at the head of the queue
  typedef enum logic [CMD_W-1:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_SOFT_DROP = 3'd4,
    CMD_HARD_DROP = 3'd5
  } cmd_e;

  // Auto-repeat FSM states
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_repeat.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// key_repeat
// Auto-repeat engine for one held button. A press raises a request at once
// and arms the initial delay (DAS_TICKS repeat ticks). When the delay runs
// out a second request is raised and the engine keeps repeating every
// ARR_TICKS ticks until cancelled.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tick_i    one-cycle repeat tick from the shared divider
//   press_i   one-cycle press pulse for this button
//   cancel_i  release (or forced release by the opposing direction); wins
//             over everything else in the same cycle
//   req_o     request to the scheduler, valid in the same cycle as its cause
// ---------------------------------------------------------------------------
module key_repeat
  import tetris_input_pkg::*;
#(
  parameter int DAS_TICKS = 40,
  parameter int ARR_TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic press_i,
  input  logic cancel_i,
  output logic req_o
);

  localparam int CNT_MAX = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_TICKS);
  localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  rpt_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             expire;

  // The counter reaches zero on this tick. Comparing with <= 1 also keeps a
  // zero load (degenerate parameters) from wrapping around.
  assign expire = (state_q != RPT_IDLE) && tick_i && (cnt_q <= CNT_ONE);

  // The request is combinational so a press reaches the pending register on
  // the very next edge; a cancel in the same cycle swallows a due repeat.
  assign req_o = !cancel_i && (press_i || expire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
    end else if (cancel_i) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
    end else if (press_i) begin
      // A fresh press restarts the initial delay from any state
      state_q <= RPT_DELAY;
      cnt_q   <= DAS_LOAD;
    end else if (expire) begin
      state_q <= RPT_REPEAT;
      cnt_q   <= ARR_LOAD;
    end else if ((state_q != RPT_IDLE) && tick_i) begin
      cnt_q   <= cnt_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/input_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// input_scheduler
// Turns debounced button press/release pulses into a queue of game commands.
// LEFT, RIGHT and SOFT_DROP auto-repeat while held; ROTATE and HARD_DROP fire
// once per press. Requests land in per-button pending bits, and one pending
// bit per cycle is moved into a small first-word-fall-through command queue
// in fixed priority order HARD_DROP > ROTATE > LEFT > RIGHT > SOFT_DROP.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   press_i      one-cycle press pulses, bit map from tetris_input_pkg
//   release_i    one-cycle release pulses, same bit map
//   cmd_ready_i  consumer takes the head command this cycle
//   cmd_valid_o  queue is not empty
//   cmd_o        head command, CMD_NONE while empty
//   fifo_full_o  queue holds FIFO_DEPTH entries
//   dropped_o    one-cycle pulse: a request merged into an already-pending one
// ---------------------------------------------------------------------------
module input_scheduler
  import tetris_input_pkg::*;
#(
  parameter int TICK_DIV   = 12500,
  parameter int DAS_TICKS  = 40,
  parameter int ARR_TICKS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] press_i,
  input  logic [NUM_BTNS-1:0] release_i,
  input  logic                cmd_ready_i,
  output logic                cmd_valid_o,
  output logic [CMD_W-1:0]    cmd_o,
  output logic                fifo_full_o,
  output logic                dropped_o
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Repeat tick divider
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Button steering and repeat engines
  // LEFT and RIGHT are mutually exclusive: pressing one cancels the other.
  // If both are pressed together LEFT wins and the RIGHT press is ignored.
  // -------------------------------------------------------------------------
  logic left_press, left_cancel, right_press, right_cancel;
  logic [NUM_BTNS-1:0] req;

  assign left_press   = press_i[BTN_LEFT];
  assign left_cancel  = release_i[BTN_LEFT] |
                        (press_i[BTN_RIGHT] & ~press_i[BTN_LEFT]);
  assign right_press  = press_i[BTN_RIGHT] & ~press_i[BTN_LEFT];
  assign right_cancel = release_i[BTN_RIGHT] | press_i[BTN_LEFT];

  key_repeat #(
    .DAS_TICKS (DAS_TICKS),
    .ARR_TICKS (ARR_TICKS)
  ) u_rpt_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .press_i  (left_press),
    .cancel_i (left_cancel),
    .req_o    (req[BTN_LEFT])
  );

  key_repeat #(
    .DAS_TICKS (DAS_TICKS),
    .ARR_TICKS (ARR_TICKS)
  ) u_rpt_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .press_i  (right_press),
    .cancel_i (right_cancel),
    .req_o    (req[BTN_RIGHT])
  );

  key_repeat #(
    .DAS_TICKS (DAS_TICKS),
    .ARR_TICKS (ARR_TICKS)
  ) u_rpt_soft (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .press_i  (press_i[BTN_SOFT_DROP]),
    .cancel_i (release_i[BTN_SOFT_DROP]),
    .req_o    (req[BTN_SOFT_DROP])
  );

  // Single-shot buttons: one request per press, releases carry no meaning
  assign req[BTN_ROTATE]    = press_i[BTN_ROTATE];
  assign req[BTN_HARD_DROP] = press_i[BTN_HARD_DROP];

  logic unused_release;
  assign unused_release = ^{release_i[BTN_ROTATE], release_i[BTN_HARD_DROP]};

  // -------------------------------------------------------------------------
  // Pending bits and priority selection
  // -------------------------------------------------------------------------
  logic [NUM_BTNS-1:0] pend_q, pend_d;
  logic [NUM_BTNS-1:0] grant, clr;
  logic [CMD_W-1:0]    grant_cmd;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                pop, wr_en, full;
  logic                dropped_q, dropped_d;

  assign full  = (occ_q == OCC_FULL);
  assign pop   = cmd_valid_o && cmd_ready_i;
  // A full queue still accepts a write in a cycle that also pops
  assign wr_en = (|pend_q) && (!full || pop);

  always_comb begin
    grant     = '0;
    grant_cmd = CMD_NONE;
    if (pend_q[BTN_HARD_DROP]) begin
      grant[BTN_HARD_DROP] = 1'b1;
      grant_cmd            = CMD_HARD_DROP;
    end else if (pend_q[BTN_ROTATE]) begin
      grant[BTN_ROTATE] = 1'b1;
      grant_cmd         = CMD_ROTATE;
    end else if (pend_q[BTN_LEFT]) begin
      grant[BTN_LEFT] = 1'b1;
      grant_cmd       = CMD_LEFT;
    end else if (pend_q[BTN_RIGHT]) begin
      grant[BTN_RIGHT] = 1'b1;
      grant_cmd        = CMD_RIGHT;
    end else if (pend_q[BTN_SOFT_DROP]) begin
      grant[BTN_SOFT_DROP] = 1'b1;
      grant_cmd            = CMD_SOFT_DROP;
    end
  end

  assign clr    = wr_en ? grant : '0;
  assign pend_d = (pend_q & ~clr) | req;
  // A request only counts as merged when its bit stays set; if that bit is
  // leaving for the queue this cycle the new request simply re-arms it.
  assign dropped_d = |(req & pend_q & ~clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      dropped_q <= dropped_d;
    end
  end

  // -------------------------------------------------------------------------
  // Command queue (first-word-fall-through)
  // -------------------------------------------------------------------------
  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Depth is a power of two, so pointers wrap by plain overflow
  assign wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_comb begin
    occ_d = occ_q;
    if (wr_en && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !wr_en) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= grant_cmd;
    end
  end

  assign cmd_valid_o = (occ_q != '0);
  assign cmd_o       = cmd_valid_o ? mem_q[rd_ptr_q] : CMD_NONE;
  assign fifo_full_o = full;
  assign dropped_o   = dropped_q;

endmodule

// File: tb/tb_input_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_input_scheduler
// Directed bench for input_scheduler with a fast repeat clock. A table of
// single-shot vectors covers latency, queue fill, merging and pops; hand
// sequences cover auto-repeat timing, simultaneous presses and reset.
// ---------------------------------------------------------------------------
module tb_input_scheduler;
  import tetris_input_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int DAS      = 3;
  localparam int ARR      = 2;
  localparam int DEPTH    = 4;

  localparam logic [4:0] B_LEFT = 5'b00001;
  localparam logic [4:0] B_ROT  = 5'b00100;
  localparam logic [4:0] B_HARD = 5'b10000;
  localparam logic [4:0] B_ALL  = 5'b11111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] press = '0;
  logic [4:0] rel = '0;
  logic       ready = 1'b0;
  logic       cmdValid;
  logic [2:0] cmd;
  logic       fifoFull;
  logic       dropped;

  int compared = 0;
  int mismatched = 0;
  int cyc;

  typedef struct {
    int         cycle;
    logic [2:0] cmd;
  } pop_t;
  pop_t popLog[$];

  typedef struct {
    logic [4:0] press;
    logic       ready;
    logic       expValid;
    logic [2:0] expCmd;
    logic       expFull;
    logic       expDropped;
  } vector_t;
  vector_t vectors[$];

  input_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .DAS_TICKS  (DAS),
    .ARR_TICKS  (ARR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_i     (press),
    .release_i   (rel),
    .cmd_ready_i (ready),
    .cmd_valid_o (cmdValid),
    .cmd_o       (cmd),
    .fifo_full_o (fifoFull),
    .dropped_o   (dropped)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle index since reset; equals the repeat divider phase by construction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Record every accepted command with the cycle it was taken in
  always @(negedge clk) begin
    if (rst_n && cmdValid && ready) begin
      pop_t e;
      e.cycle = cyc;
      e.cmd   = cmd;
      popLog.push_back(e);
    end
  end

  // Hard stop in case something wedges the flow
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one value and count it
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle worth of inputs just after the rising edge
  task automatic applyStimulus(input logic [4:0] p, input logic [4:0] r,
                               input logic rdy);
    @(posedge clk);
    #1;
    press = p;
    rel   = r;
    ready = rdy;
  endtask

  task automatic addVector(input logic [4:0] p, input logic rdy,
                           input logic v, input logic [2:0] c,
                           input logic f, input logic d);
    vector_t e;
    e.press      = p;
    e.ready      = rdy;
    e.expValid   = v;
    e.expCmd     = c;
    e.expFull    = f;
    e.expDropped = d;
    vectors.push_back(e);
  endtask

  initial begin
    int p;
    int tickCount;
    int expCycles[$];
    logic [2:0] expOrder[$];

    $display("[TB] start");

    // ---------------- reset, with presses held that must be ignored -------
    press = B_ALL;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset valid", cmdValid, 0);
    checkOutput("reset cmd", cmd, 0);
    checkOutput("reset full", fifoFull, 0);
    checkOutput("reset dropped", dropped, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    press = '0;
    repeat (6) applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("post-reset valid", cmdValid, 0);
    checkOutput("post-reset dropped", dropped, 0);

    // ---------------- table: single-shot latency, fill, merge, pops -------
    //         press   rdy   valid cmd  full drop
    addVector(B_ROT,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    addVector('0,     1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    addVector('0,     1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    addVector('0,     1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    addVector('0,     1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    addVector(B_HARD, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    addVector(B_ROT,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    addVector(B_HARD, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    addVector(B_ROT,  1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    addVector('0,     1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    addVector(B_ROT,  1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    addVector(B_ROT,  1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    addVector('0,     1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
    addVector('0,     1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
    addVector('0,     1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    addVector('0,     1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    addVector('0,     1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    addVector('0,     1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    addVector('0,     1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    addVector('0,     1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    addVector('0,     1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i].press, '0, vectors[i].ready);
      @(negedge clk);
      checkOutput($sformatf("vec%0d valid", i), cmdValid, vectors[i].expValid);
      checkOutput($sformatf("vec%0d cmd", i), cmd, vectors[i].expCmd);
      checkOutput($sformatf("vec%0d full", i), fifoFull, vectors[i].expFull);
      checkOutput($sformatf("vec%0d dropped", i), dropped, vectors[i].expDropped);
    end

    // ---------------- LEFT held 40 cycles: delay then repeat --------------
    popLog.delete();
    applyStimulus(B_LEFT, '0, 1'b1);
    p = cyc;
    repeat (39) applyStimulus('0, '0, 1'b1);
    applyStimulus('0, B_LEFT, 1'b1);
    repeat (20) applyStimulus('0, '0, 1'b1);

    expCycles.delete();
    expCycles.push_back(p + 2);
    tickCount = 0;
    for (int c = p + 1; c <= p + 39; c++) begin
      if (c % TICK_DIV == TICK_DIV - 1) begin
        tickCount++;
        if (tickCount >= DAS && (tickCount - DAS) % ARR == 0)
          expCycles.push_back(c + 2);
      end
    end
    checkOutput("left repeat count", popLog.size(), expCycles.size());
    for (int i = 0; i < expCycles.size() && i < popLog.size(); i++) begin
      checkOutput($sformatf("left pop%0d cycle", i), popLog[i].cycle, expCycles[i]);
      checkOutput($sformatf("left pop%0d cmd", i), popLog[i].cmd, 1);
    end

    // ---------------- all buttons in one cycle, queue blocked -------------
    popLog.delete();
    applyStimulus(B_ALL, '0, 1'b0);
    p = cyc;
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("all p+1 dropped", dropped, 0);
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("all p+2 dropped", dropped, 0);
    applyStimulus('0, '0, 1'b0);
    applyStimulus('0, '0, 1'b0);
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("all full", fifoFull, 1);
    checkOutput("all head cmd", cmd, 5);
    applyStimulus('0, B_ALL, 1'b0);
    repeat (6) applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("all still full", fifoFull, 1);
    checkOutput("all no merge", dropped, 0);
    repeat (8) applyStimulus('0, '0, 1'b1);
    @(negedge clk);
    checkOutput("all drained valid", cmdValid, 0);
    expOrder = '{3'd5, 3'd3, 3'd1, 3'd4};
    checkOutput("all pop count", popLog.size(), expOrder.size());
    for (int i = 0; i < expOrder.size() && i < popLog.size(); i++)
      checkOutput($sformatf("all order%0d", i), popLog[i].cmd, expOrder[i]);

    // ---------------- reset in the middle of a repeat ---------------------
    popLog.delete();
    applyStimulus(B_LEFT, '0, 1'b0);
    p = cyc;
    repeat (24) applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("mid-repeat valid", cmdValid, 1);
    checkOutput("mid-repeat cmd", cmd, 1);
    checkOutput("mid-repeat full", fifoFull, 0);
    #1;
    rst_n = 1'b0;
    press = B_LEFT;
    #1;
    checkOutput("async reset valid", cmdValid, 0);
    checkOutput("async reset cmd", cmd, 0);
    checkOutput("async reset full", fifoFull, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    press = '0;
    ready = 1'b1;
    repeat (30) applyStimulus('0, '0, 1'b1);
    @(negedge clk);
    checkOutput("after reset no cmds", popLog.size(), 0);
    checkOutput("after reset valid", cmdValid, 0);

    // ---------------- press on the first edge after reset release ---------
    popLog.delete();
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    press = B_ROT;
    ready = 1'b1;
    repeat (6) applyStimulus('0, '0, 1'b1);
    @(negedge clk);
    checkOutput("first press count", popLog.size(), 1);
    if (popLog.size() > 0) begin
      checkOutput("first press cycle", popLog[0].cycle, 2);
      checkOutput("first press cmd", popLog[0].cmd, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/input_scheduler.md
INPUT_SCHEDULER -- requirements
Module: input_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 12500, clk cycles per repeat tick (200 Hz at 2.5 MHz).
REQ-002 Parameter DAS_TICKS, default 40, ticks from press to first auto-repeat.
REQ-003 Parameter ARR_TICKS, default 8, ticks between subsequent auto-repeats.
REQ-004 Parameter FIFO_DEPTH, default 4, command queue entries (power of two, >=2).
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 press  input  5  one-cycle press pulses from per-button debouncers; bit 0 LEFT, 1 RIGHT, 2 ROTATE, 3 SOFT_DROP, 4 HARD_DROP.
REQ-008 release  input  5  one-cycle release pulses, same bit map.
REQ-009 cmd_ready  input  1  game-logic consumer accepts head command.
REQ-010 cmd_valid  output  1  queue non-empty.
REQ-011 cmd  output  3  head command: 0 NONE, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DROP, 5 HARD_DROP.
REQ-012 fifo_full  output  1  queue holds FIFO_DEPTH entries.
REQ-013 dropped  output  1  one-cycle pulse when a request merges into an already-pending request.

Function
REQ-014 A free-running tick counter SHALL count 0..TICK_DIV-1 and assert an internal tick for one cycle at wrap.
REQ-015 LEFT, RIGHT, SOFT_DROP SHALL each have a repeat FSM: IDLE, DELAY, REPEAT.
REQ-016 IDLE + press: raise request, load counter DAS_TICKS, go DELAY.
REQ-017 DELAY/REPEAT: decrement counter on tick; on counter reaching 0 raise request, load ARR_TICKS, go/stay REPEAT.
REQ-018 Release in any state SHALL go to IDLE in the same cycle, cancelling any repeat due that cycle; an already-pending request is kept.
REQ-019 LEFT press while RIGHT not IDLE SHALL force RIGHT to IDLE (and vice versa); simultaneous LEFT and RIGHT press: LEFT enters DELAY, RIGHT stays IDLE.
REQ-020 ROTATE and HARD_DROP SHALL raise one request per press, no auto-repeat.
REQ-021 Requests SHALL set a per-button pending bit; a request hitting a set bit SHALL pulse dropped one cycle after the request.
REQ-022 Each cycle at most one pending bit SHALL be written to the FIFO, fixed priority HARD_DROP > ROTATE > LEFT > RIGHT > SOFT_DROP, clearing that bit.
REQ-023 Pending bits SHALL be held while fifo_full, except a write is allowed when the same cycle pops (cmd_valid && cmd_ready).
REQ-024 Latency: press at cycle N, FIFO empty, no higher-priority pending -> pending set at N+1, written N+1, cmd_valid at N+2.
REQ-025 Queue SHALL be first-word-fall-through; cmd SHALL be 0 when empty; pop only when cmd_valid && cmd_ready.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-027 cmd_ready while empty SHALL have no effect.

Reset
REQ-028 rst_n low SHALL asynchronously clear tick counter, repeat counters, pending bits, FIFO pointers/occupancy; FSMs to IDLE.
REQ-029 During/after reset cmd_valid=0, cmd=0, fifo_full=0, dropped=0; reset mid-repeat discards all queued and pending commands.
REQ-030 press/release during reset SHALL be ignored; first press recognised on first clk edge after rst_n rises.

Structure
REQ-031 Command encoding, button index constants and FSM state encoding SHALL live in shared package tetris_input_pkg.
REQ-032 Repeat FSM plus its counter SHALL be sub-module key_repeat, instantiated three times.
REQ-033 FIFO SHALL stay inline in input_scheduler.

Verification (TICK_DIV=4, DAS_TICKS=3, ARR_TICKS=2)
REQ-034 ROTATE press, cmd_ready=1 -> exactly one cmd=3 two cycles later, none after.
REQ-035 LEFT held 40 cycles then released -> cmd=1 at press+2, next after 3 ticks, then every 2 ticks; none after release.
REQ-036 press=5'b11111 in one cycle, cmd_ready=0 -> queue order 5,3,1,4 (RIGHT suppressed), fifo_full=1, SOFT_DROP pending none.
REQ-037 FIFO full, ROTATE pressed twice -> second press pulses dropped; after popping one entry cmd 3 enters once.
REQ-038 rst_n low while LEFT in REPEAT with 3 queued -> cmd_valid=0 immediately; no commands after rst_n rises until new press.
